// File: rtl/gate_model_bist_pkg.sv
// Shared definitions for the gate-model BIST engine.
// Holds the FSM state encoding, the pattern counter width and the
// default Galois feedback masks for the stimulus LFSR and the
// response MISR.
package gate_model_bist_pkg;

    // FSM state encoding, kept as plain constants so older tools can
    // consume the same package.
    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t RUN    = 2'd1;
    localparam state_t FINISH = 2'd2;

    // Pattern counter width; PATTERNS is capped at 2^16-1, so the
    // counter never wraps.
    localparam int CNT_W = 16;

    // Maximal-length right-shift Galois masks:
    // 15 bits: x^15 + x^14 + 1
    // 16 bits: x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [14:0] DEFAULT_LFSR_TAPS = 15'h6000;
    localparam logic [15:0] DEFAULT_MISR_TAPS = 16'hB400;

endpackage

// File: rtl/gate_model_bist_galois_shift.sv
// galois_shift: one step of a right-shifting Galois shift register.
// The next state is the current state shifted right by one, XORed with
// TAPS when the bit shifted out is 1, then XORed with data_i.
// Tying data_i to zero gives a plain LFSR; feeding a response into it
// gives a MISR.
//
// Ports:
//   state_i : current register value
//   data_i  : parallel data folded in on this step (zero for an LFSR)
//   next_o  : value the register takes after this step
module galois_shift
    import gate_model_bist_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_o
);

    // Shift right, apply the feedback mask when the outgoing bit is set,
    // then compact the parallel input.
    assign next_o = {1'b0, state_i[WIDTH-1:1]}
                  ^ (state_i[0] ? TAPS : '0)
                  ^ data_i;

endmodule

// File: rtl/gate_model_bist.sv
// gate_model_bist: built-in self test for a combinational gate model.
// A START request launches a run of PATTERNS stimulus vectors from an
// LFSR seeded with SEED. The gate model's response is compacted into a
// MISR signature on the same edge that retires each pattern. When the
// run ends, DONE is raised and PASS reports whether the signature
// matches GOLDEN.
//
// Ports:
//   CLK       : clock, rising edge active
//   RST       : synchronous active-high reset, takes priority over START
//   START     : run request, honoured in IDLE or FINISH only
//   GOLDEN    : expected signature
//   DUT_IN    : registered stimulus driven to the gate model
//   DUT_OUT   : combinational response of the gate model
//   BUSY      : registered, high while a run is in progress
//   DONE      : registered, high once a run has completed
//   SIGNATURE : registered compacted response
//   PASS      : DONE and SIGNATURE == GOLDEN
module gate_model_bist
    import gate_model_bist_pkg::*;
#(
    parameter int              IN_W      = 15,
    parameter int              OUT_W     = 10,
    parameter int              SIG_W     = 16,
    parameter int              PATTERNS  = 1000,
    parameter logic [IN_W-1:0]  SEED      = IN_W'(1),
    parameter logic [IN_W-1:0]  LFSR_TAPS = IN_W'(DEFAULT_LFSR_TAPS),
    parameter logic [SIG_W-1:0] MISR_TAPS = SIG_W'(DEFAULT_MISR_TAPS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [SIG_W-1:0] GOLDEN,
    output logic [IN_W-1:0]  DUT_IN,
    input  logic [OUT_W-1:0] DUT_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [SIG_W-1:0] SIGNATURE,
    output logic             PASS
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  dutIn_q, dutIn_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IN_W-1:0]  lfsrNext;
    logic [SIG_W-1:0] misrNext;
    logic [SIG_W-1:0] misrData;

    // The response is narrower than (or as wide as) the signature, so it
    // is zero-extended before being folded into the MISR.
    assign misrData = SIG_W'(DUT_OUT);

    // Stimulus generator: free-running Galois LFSR step.
    galois_shift #(
        .WIDTH (IN_W),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .state_i (dutIn_q),
        .data_i  ('0),
        .next_o  (lfsrNext)
    );

    // Response compactor: the gate model output for the pattern currently
    // on DUT_IN is absorbed combinationally, giving zero-latency sampling.
    galois_shift #(
        .WIDTH (SIG_W),
        .TAPS  (MISR_TAPS)
    ) u_misr (
        .state_i (sig_q),
        .data_i  (misrData),
        .next_o  (misrNext)
    );

    // Next-state logic. START is only looked at outside RUN, so a request
    // during a run is dropped. The final RUN edge still advances the LFSR
    // and absorbs the last response before the move to FINISH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dutIn_d = dutIn_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE, FINISH: begin
                if (START) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    dutIn_d = SEED;
                    sig_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                sig_d   = misrNext;
                dutIn_d = lfsrNext;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-run discards
    // the partial signature and never produces a DONE pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dutIn_q <= SEED;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dutIn_q <= dutIn_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign DUT_IN    = dutIn_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SIGNATURE = sig_q;
    assign PASS      = done_q && (sig_q == GOLDEN);

endmodule

// File: tb/tb_gate_model_bist.sv
// Self-checking bench for gate_model_bist. Three small 4-bit instances
// share clock and reset:
//   A: PATTERNS=15, exercises full LFSR period, ignored START, abort by RST
//   B: PATTERNS=2, table of hand-computed signatures and PASS values
//   C: PATTERNS=3, START held high for back-to-back runs
module tb_gate_model_bist;

    logic CLK = 1'b0;
    logic RST;

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    logic       startA, startB, startC;
    logic [3:0] goldenA, goldenB, goldenC;
    logic [3:0] dutInA, dutInB, dutInC;
    logic [3:0] dutOutA, dutOutB, dutOutC;
    logic [3:0] sigA, sigB, sigC;
    logic       busyA, busyB, busyC;
    logic       doneA, doneB, doneC;
    logic       passA, passB, passC;

    logic       modeA;
    logic       modeB;
    logic [3:0] constB;

    // Gate models: either a constant response or the inverted stimulus.
    assign dutOutA = modeA ? ~dutInA : 4'h0;
    assign dutOutB = modeB ? ~dutInB : constB;
    assign dutOutC = ~dutInC;

    gate_model_bist #(
        .IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(15), .SEED(4'b0001),
        .LFSR_TAPS(4'b1100), .MISR_TAPS(4'b1100)
    ) u_dutA (
        .CLK(CLK), .RST(RST), .START(startA), .GOLDEN(goldenA),
        .DUT_IN(dutInA), .DUT_OUT(dutOutA), .BUSY(busyA), .DONE(doneA),
        .SIGNATURE(sigA), .PASS(passA)
    );

    gate_model_bist #(
        .IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(2), .SEED(4'b0001),
        .LFSR_TAPS(4'b1100), .MISR_TAPS(4'b1100)
    ) u_dutB (
        .CLK(CLK), .RST(RST), .START(startB), .GOLDEN(goldenB),
        .DUT_IN(dutInB), .DUT_OUT(dutOutB), .BUSY(busyB), .DONE(doneB),
        .SIGNATURE(sigB), .PASS(passB)
    );

    gate_model_bist #(
        .IN_W(4), .OUT_W(4), .SIG_W(4), .PATTERNS(3), .SEED(4'b0001),
        .LFSR_TAPS(4'b1100), .MISR_TAPS(4'b1100)
    ) u_dutC (
        .CLK(CLK), .RST(RST), .START(startC), .GOLDEN(goldenC),
        .DUT_IN(dutInC), .DUT_OUT(dutOutC), .BUSY(busyC), .DONE(doneC),
        .SIGNATURE(sigC), .PASS(passC)
    );

    int checks = 0;
    int fails  = 0;

    // Table record for instance B: gate model setting, golden and the
    // hand-computed signature / PASS after two patterns.
    typedef struct {
        logic       invert;
        logic [3:0] constVal;
        logic [3:0] golden;
        logic [3:0] expSig;
        logic       expPass;
    } vecB_t;

    vecB_t vecs[9];

    logic [15:0] seenMask;
    int          distinctA;
    logic        zeroSeenA;
    logic [3:0]  expSigA;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] lfsrStep(input logic [3:0] s);
        return {1'b0, s[3:1]} ^ (s[0] ? 4'b1100 : 4'b0000);
    endfunction

    function automatic logic [3:0] misrStep(input logic [3:0] s, input logic [3:0] d);
        return lfsrStep(s) ^ d;
    endfunction

    // Runs instance A once, optionally pulsing START during the run,
    // and tracks BUSY length and visited stimulus values.
    task automatic applyStimulus(input logic disturb, output int busyCycles,
                                 output logic timedOut);
        @(negedge CLK);
        startA = 1'b1;
        @(negedge CLK);
        startA     = 1'b0;
        busyCycles = 0;
        timedOut   = 1'b1;
        seenMask   = '0;
        distinctA  = 0;
        zeroSeenA  = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (doneA) begin
                timedOut = 1'b0;
                break;
            end
            if (busyA) begin
                busyCycles++;
                if (dutInA == 4'h0) zeroSeenA = 1'b1;
                else if (!seenMask[dutInA]) begin
                    seenMask[dutInA] = 1'b1;
                    distinctA++;
                end
            end
            checkOutput("passA_low_while_not_done", 32'(passA), 32'd0);
            startA = (disturb && (cyc == 2 || cyc == 6)) ? 1'b1 : 1'b0;
            @(negedge CLK);
        end
        startA = 1'b0;
    endtask

    initial begin
        int         busyCycles;
        logic       timedOut;
        logic       sawDone;
        logic [3:0] s;
        logic [3:0] m;

        vecs[0] = '{1'b0, 4'h1, 4'hD, 4'hD, 1'b1};
        vecs[1] = '{1'b0, 4'h1, 4'h0, 4'hD, 1'b0};
        vecs[2] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[3] = '{1'b0, 4'h2, 4'h3, 4'h3, 1'b1};
        vecs[4] = '{1'b0, 4'h3, 4'h0, 4'hE, 1'b0};
        vecs[5] = '{1'b0, 4'hF, 4'h4, 4'h4, 1'b1};
        vecs[6] = '{1'b0, 4'h8, 4'hC, 4'hC, 1'b1};
        vecs[7] = '{1'b0, 4'h5, 4'h0, 4'hB, 1'b0};
        vecs[8] = '{1'b1, 4'h0, 4'h4, 4'h4, 1'b1};

        // Reference signature for A with the inverted-stimulus gate model.
        s = 4'h1;
        m = 4'h0;
        for (int i = 0; i < 15; i++) begin
            m = misrStep(m, ~s);
            s = lfsrStep(s);
        end
        expSigA = m;

        RST     = 1'b1;
        startA  = 1'b0;
        startB  = 1'b0;
        startC  = 1'b0;
        goldenA = 4'h0;
        goldenB = 4'h0;
        goldenC = 4'h0;
        modeA   = 1'b1;
        modeB   = 1'b0;
        constB  = 4'h0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Reset state; GOLDEN matches the cleared signature, PASS must stay low.
        checkOutput("reset_busy", 32'(busyA), 32'd0);
        checkOutput("reset_done", 32'(doneA), 32'd0);
        checkOutput("reset_sig", 32'(sigA), 32'd0);
        checkOutput("reset_dutin", 32'(dutInA), 32'd1);
        checkOutput("reset_pass", 32'(passA), 32'd0);
        checkOutput("reset_pass_b", 32'(passB), 32'd0);

        // Full-period undisturbed run on A.
        goldenA = expSigA;
        applyStimulus(1'b0, busyCycles, timedOut);
        checkOutput("a_timeout", 32'(timedOut), 32'd0);
        checkOutput("a_busy_cycles", 32'(busyCycles), 32'd15);
        checkOutput("a_distinct", 32'(distinctA), 32'd15);
        checkOutput("a_zero_seen", 32'(zeroSeenA), 32'd0);
        checkOutput("a_dutin_at_done", 32'(dutInA), 32'd1);
        checkOutput("a_sig", 32'(sigA), 32'(expSigA));
        checkOutput("a_pass", 32'(passA), 32'd1);

        // Same run with ignored START pulses in the middle.
        applyStimulus(1'b1, busyCycles, timedOut);
        checkOutput("a_dist_timeout", 32'(timedOut), 32'd0);
        checkOutput("a_dist_busy_cycles", 32'(busyCycles), 32'd15);
        checkOutput("a_dist_sig", 32'(sigA), 32'(expSigA));
        checkOutput("a_dist_pass", 32'(passA), 32'd1);

        // Response tied low gives an all-zero signature.
        modeA   = 1'b0;
        goldenA = 4'h0;
        applyStimulus(1'b0, busyCycles, timedOut);
        checkOutput("a_zero_timeout", 32'(timedOut), 32'd0);
        checkOutput("a_zero_sig", 32'(sigA), 32'd0);
        checkOutput("a_zero_pass", 32'(passA), 32'd1);

        // Abort by reset on the fifth RUN cycle.
        modeA = 1'b1;
        @(negedge CLK);
        startA = 1'b1;
        @(negedge CLK);
        startA = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("abort_busy_before", 32'(busyA), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("abort_busy", 32'(busyA), 32'd0);
        checkOutput("abort_done", 32'(doneA), 32'd0);
        checkOutput("abort_sig", 32'(sigA), 32'd0);
        checkOutput("abort_dutin", 32'(dutInA), 32'd1);
        checkOutput("abort_pass", 32'(passA), 32'd0);
        sawDone = 1'b0;
        repeat (30) begin
            @(negedge CLK);
            if (doneA || busyA) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);

        // Table-driven two-pattern signatures on B.
        for (int v = 0; v < 9; v++) begin
            @(negedge CLK);
            modeB   = vecs[v].invert;
            constB  = vecs[v].constVal;
            goldenB = vecs[v].golden;
            startB  = 1'b1;
            @(negedge CLK);
            startB     = 1'b0;
            busyCycles = 0;
            timedOut   = 1'b1;
            for (int cyc = 0; cyc < 20; cyc++) begin
                if (doneB) begin
                    timedOut = 1'b0;
                    break;
                end
                if (busyB) busyCycles++;
                @(negedge CLK);
            end
            checkOutput($sformatf("b%0d_timeout", v), 32'(timedOut), 32'd0);
            checkOutput($sformatf("b%0d_busy_cycles", v), 32'(busyCycles), 32'd2);
            checkOutput($sformatf("b%0d_sig", v), 32'(sigB), 32'(vecs[v].expSig));
            checkOutput($sformatf("b%0d_pass", v), 32'(passB), 32'(vecs[v].expPass));
            checkOutput($sformatf("b%0d_dutin", v), 32'(dutInB), 32'd6);
            // FINISH must hold even while the response keeps changing.
            constB = ~constB;
            repeat (2) @(negedge CLK);
            checkOutput($sformatf("b%0d_hold_done", v), 32'(doneB), 32'd1);
            checkOutput($sformatf("b%0d_hold_sig", v), 32'(sigB), 32'(vecs[v].expSig));
            checkOutput($sformatf("b%0d_hold_dutin", v), 32'(dutInB), 32'd6);
        end

        // Back-to-back runs on C with START held high: 3 busy, 1 done.
        goldenC = 4'hB;
        @(negedge CLK);
        startC = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("c_busy_%0d", i), 32'(busyC), 32'((i % 4) != 3));
            checkOutput($sformatf("c_done_%0d", i), 32'(doneC), 32'((i % 4) == 3));
            if ((i % 4) == 3) begin
                checkOutput($sformatf("c_sig_%0d", i), 32'(sigC), 32'hB);
                checkOutput($sformatf("c_dutin_%0d", i), 32'(dutInC), 32'h3);
                checkOutput($sformatf("c_pass_%0d", i), 32'(passC), 32'd1);
            end
            @(negedge CLK);
        end
        startC = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gate_model_bist.md
GATE_MODEL_BIST -- requirements
Module: gate_model_bist

Interface
REQ-001 The block SHALL have parameter IN_W, default 15, meaning the width of the stimulus applied to the gate model under test.
REQ-002 The block SHALL have parameter OUT_W, default 10, meaning the width of the response read back from the gate model under test.
REQ-003 The block SHALL have parameter SIG_W, default 16, meaning the signature width; SIG_W >= OUT_W is required.
REQ-004 The block SHALL have parameter PATTERNS, default 1000, meaning the number of patterns per run; the legal range is 1..2^16-1.
REQ-005 The block SHALL have parameter SEED, default 1, meaning the initial stimulus value; it is non-zero and IN_W bits wide.
REQ-006 The block SHALL have parameters LFSR_TAPS (IN_W bits) and MISR_TAPS (SIG_W bits), meaning the Galois feedback masks.
REQ-007 The block SHALL have port CLK, input, 1 bit: the single clock, with the rising edge active.
REQ-008 The block SHALL have port RST, input, 1 bit: a synchronous, active-high reset.
REQ-009 The block SHALL have port START, input, 1 bit: a run request.
REQ-010 The block SHALL have port GOLDEN, input, SIG_W bits: the expected signature.
REQ-011 The block SHALL have port DUT_IN, output, IN_W bits, registered: the stimulus driven to the gate model.
REQ-012 The block SHALL have port DUT_OUT, input, OUT_W bits: the combinational response of the gate model.
REQ-013 The block SHALL have port BUSY, output, 1 bit, registered: high while a run is in progress.
REQ-014 The block SHALL have port DONE, output, 1 bit, registered: high when a run has completed.
REQ-015 The block SHALL have port SIGNATURE, output, SIG_W bits, registered: the compacted response.
REQ-016 The block SHALL have port PASS, output, 1 bit: DONE AND (SIGNATURE == GOLDEN), combinational from registers.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-018 In IDLE or FINISH, START=1 at a clock edge SHALL cause the following register updates, all on that same edge:
  - DUT_IN loads SEED.
  - SIGNATURE clears to 0.
  - The pattern counter CNT clears to 0.
  - The state moves to RUN.
  - BUSY is set and DONE is cleared.
REQ-019 In RUN, each edge SHALL perform the following updates:
  - SIGNATURE absorbs the current DUT_OUT: sig_next = ({0, sig[SIG_W-1:1]} XOR (sig[0] ? MISR_TAPS : 0)) XOR zero-extend(DUT_OUT).
  - DUT_IN advances: lfsr_next = {0, s[IN_W-1:1]} XOR (s[0] ? LFSR_TAPS : 0).
  - CNT increments by 1.
REQ-020 DUT_OUT SHALL be sampled on the same edge that retires its pattern; the gate model is combinational, so the latency is zero pipeline stages.
REQ-021 On the edge where CNT == PATTERNS-1, the state SHALL move to FINISH, BUSY SHALL clear and DONE SHALL set; exactly PATTERNS samples are absorbed.
REQ-022 START asserted during RUN SHALL be ignored, with no restart and no effect on CNT.
REQ-023 In FINISH, DUT_IN, SIGNATURE and DONE SHALL hold until START or RST.
REQ-024 START held high continuously SHALL restart a run on the first edge spent in FINISH.
REQ-025 CNT SHALL be 16 bits wide and SHALL never wrap, because PATTERNS <= 2^16-1.
REQ-026 PASS SHALL be 0 whenever DONE = 0.

Reset
REQ-027 RST=1 at an edge SHALL produce the following state, and RST SHALL take priority over START:
  - state = IDLE, CNT = 0, SIGNATURE = 0.
  - DUT_IN = SEED.
  - BUSY = 0, DONE = 0 (hence PASS = 0).
REQ-028 RST asserted mid-RUN SHALL abort the run, with no DONE pulse and the partial signature discarded.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/RUN/FINISH), the CNT width constant (16) and the default tap masks.
REQ-030 One sub-module, galois_shift, SHALL be parameterised by width and taps and instantiated twice:
  - as the LFSR, with no data input;
  - as the MISR, with the data input set to DUT_OUT.

Verification
REQ-031 With IN_W=4, SEED=4'b0001, LFSR_TAPS=4'b1100 and PATTERNS=15, a START pulse SHALL give the following response:
  - BUSY is high for 15 cycles.
  - DUT_IN visits 15 distinct non-zero values.
  - DUT_IN equals 4'b0001 again at DONE.
REQ-032 With SIG_W=4, MISR_TAPS=4'b1100, DUT_OUT tied to 1 and PATTERNS=2, SIGNATURE SHALL read 4'hD at DONE; with GOLDEN=4'hD PASS SHALL be 1, and with GOLDEN=4'h0 PASS SHALL be 0.
REQ-033 With DUT_OUT tied to 0 and any PATTERNS, SIGNATURE SHALL be 0 at DONE.
REQ-034 START pulses on RUN cycles 3 and 7 SHALL leave the run length equal to PATTERNS and the signature identical to an undisturbed run.
REQ-035 RST at RUN cycle 5 SHALL produce IDLE on the next edge, with BUSY=0, DONE=0, SIGNATURE=0 and DUT_IN=SEED, and no DONE pulse thereafter.
REQ-036 START held high continuously with PATTERNS=3 SHALL give back-to-back runs, each RUN phase 3 cycles long separated by a single FINISH cycle, and identical signatures for each run.
